ides4_align_ctrl: RTL and testbench

- Word-alignment (bit-slip) controller for a bank of Gowin IDES4 1:4 input deserialisers.
- Runs in the PCLK domain. Drives each lane's CALIB input with single-cycle slip pulses until the lane's 4-bit word matches a training pattern for a set number of consecutive cycles.
- Calibrates the lanes one at a time, then reports per-lane lock, slip count and an overall done/fail status to the capture logic.

---
 rtl/ides4_align_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_ides4_align_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ides4_align_ctrl.sv
// ---------------------------------------------------------------------------
// | Module   : ides4_align_ctrl                                              |
// | Brief    : Bit-slip word-alignment controller for a bank of IDES4 lanes.  |
// |            Slips each lane in turn until its word locks to PATTERN.      |
// | Revision : 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module ides4_align_ctrl #(
  parameter int         LANES   = 2,
  parameter logic [3:0] PATTERN = 4'b0011,
  parameter int         SETTLE  = 4,
  parameter int         MATCHES = 8
) (
  input  logic                 pclk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic [4*LANES-1:0]   q_i,
  output logic [LANES-1:0]     calib_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 fail_o,
  output logic [LANES-1:0]     lock_o,
  output logic [2*LANES-1:0]   slips_o
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_SLIP  = 3'd3;
  localparam logic [2:0] S_NEXT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [3:0]    SETTLE_LD  = 4'(SETTLE);
  localparam logic [7:0]    MATCH_LAST = 8'(MATCHES - 1);
  localparam logic [LW-1:0] LANE_LAST  = LW'(LANES - 1);

  logic [2:0]         state_q, state_d;
  logic [LW-1:0]      lane_q, lane_d;
  logic [1:0]         tries_q, tries_d;
  logic [3:0]         settle_q, settle_d;
  logic [7:0]         match_q, match_d;
  logic [LANES-1:0]   calib_q, calib_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               fail_q, fail_d;
  logic [LANES-1:0]   lock_q, lock_d;
  logic [2*LANES-1:0] slips_q, slips_d;

  logic [3:0] lane_word;
  logic       word_match;

  always_comb begin
    lane_word = 4'b0000;
    for (int n = 0; n < LANES; n++) begin
      if (lane_q == LW'(n)) lane_word = q_i[4*n +: 4];
    end
  end

  assign word_match = (lane_word == PATTERN);

  // State register (also holds every counter and registered output)
  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      lane_q   <= '0;
      tries_q  <= '0;
      settle_q <= '0;
      match_q  <= '0;
      calib_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
      lock_q   <= '0;
      slips_q  <= '0;
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      tries_q  <= tries_d;
      settle_q <= settle_d;
      match_q  <= match_d;
      calib_q  <= calib_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      fail_q   <= fail_d;
      lock_q   <= lock_d;
      slips_q  <= slips_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_WAIT;
      S_WAIT:  if (settle_q <= 4'd1) state_d = S_CHECK;
      S_CHECK: begin
        if (word_match) begin
          if (match_q == MATCH_LAST) state_d = S_NEXT;
        end else if (tries_q != 2'd3) begin
          state_d = S_SLIP;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_SLIP:  state_d = S_WAIT;
      S_NEXT:  state_d = (lane_q == LANE_LAST) ? S_DONE : S_WAIT;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    lane_d   = lane_q;
    tries_d  = tries_q;
    settle_d = settle_q;
    match_d  = match_q;
    calib_d  = '0;
    done_d   = done_q;
    fail_d   = fail_q;
    lock_d   = lock_q;
    slips_d  = slips_q;
    busy_d   = (state_d != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          lock_d   = '0;
          slips_d  = '0;
          fail_d   = 1'b0;
          done_d   = 1'b0;
          lane_d   = '0;
          tries_d  = 2'd0;
          settle_d = SETTLE_LD;
        end
      end
      S_WAIT: begin
        settle_d = settle_q - 4'd1;
        if (settle_q <= 4'd1) match_d = 8'd0;
      end
      S_CHECK: begin
        if (word_match) begin
          match_d = match_q + 8'd1;
          for (int n = 0; n < LANES; n++) begin
            if ((match_q == MATCH_LAST) && (lane_q == LW'(n))) lock_d[n] = 1'b1;
          end
        end else begin
          match_d = 8'd0;
          // Pulse is registered so it is high exactly during the SLIP cycle
          for (int n = 0; n < LANES; n++) begin
            if ((tries_q != 2'd3) && (lane_q == LW'(n))) calib_d[n] = 1'b1;
          end
          if (tries_q == 2'd3) fail_d = 1'b1;
        end
      end
      S_SLIP: begin
        for (int n = 0; n < LANES; n++) begin
          if (lane_q == LW'(n)) slips_d[2*n +: 2] = slips_q[2*n +: 2] + 2'd1;
        end
        tries_d  = tries_q + 2'd1;
        settle_d = SETTLE_LD;
      end
      S_NEXT: begin
        if (lane_q == LANE_LAST) begin
          done_d = 1'b1;
        end else begin
          lane_d   = lane_q + LW'(1);
          tries_d  = 2'd0;
          settle_d = SETTLE_LD;
        end
      end
      default: ;
    endcase
  end

  assign calib_o = calib_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign fail_o  = fail_q;
  assign lock_o  = lock_q;
  assign slips_o = slips_q;

endmodule

`default_nettype wire

// File: tb/tb_ides4_align_ctrl.sv
// ---------------------------------------------------------------------------
// | Module   : tb_ides4_align_ctrl                                           |
// | Brief    : Randomised bench with IDES4 lane models and a pass-level      |
// |            reference model of the alignment controller.                  |
// | Revision : 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_ides4_align_ctrl;

  localparam int         LANES   = 2;
  localparam logic [3:0] PAT     = 4'b0011;
  localparam int         SETTLE  = 4;
  localparam int         MATCHES = 8;

  logic                 pclk = 1'b0;
  logic                 reset = 1'b1;
  logic                 start_i = 1'b0;
  logic [4*LANES-1:0]   q_i;
  logic [LANES-1:0]     calib_o;
  logic                 busy_o;
  logic                 done_o;
  logic                 fail_o;
  logic [LANES-1:0]     lock_o;
  logic [2*LANES-1:0]   slips_o;

  ides4_align_ctrl #(
    .LANES(LANES), .PATTERN(PAT), .SETTLE(SETTLE), .MATCHES(MATCHES)
  ) dut (
    .pclk(pclk), .reset(reset), .start_i(start_i), .q_i(q_i),
    .calib_o(calib_o), .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o),
    .lock_o(lock_o), .slips_o(slips_o)
  );

  always #5 pclk = ~pclk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Lane stimulus: mode 0 = rotated PAT by (off + slips), 1 = dead, 2 = always PAT
  int mode   [LANES];
  int off    [LANES];
  int gl_rel [LANES];
  int gl_cyc [LANES];

  int cyc = 0;
  int pulse_total [LANES];
  int pulse_base  [LANES];
  int pl_cyc [$];
  int pl_val [$];
  int bad_calib = 0;
  logic [LANES-1:0] prev_calib = '0;

  function automatic logic [3:0] lane_word(int md, int of, int gc, int sl, int c);
    logic [3:0] p;
    p = PAT;
    if (c == gc) return ~PAT;
    if (md == 1) return 4'b0000;
    if (md == 2) return PAT;
    for (int k = 0; k < (of + sl) % 4; k++) p = {p[2:0], p[3]};
    return p;
  endfunction

  always_comb begin
    q_i = '0;
    for (int n = 0; n < LANES; n++)
      q_i[4*n +: 4] = lane_word(mode[n], off[n], gl_cyc[n], pulse_total[n] - pulse_base[n], cyc);
  end

  always @(posedge pclk) cyc <= cyc + 1;

  always @(negedge pclk) begin
    if (calib_o != '0) begin
      pl_cyc.push_back(cyc);
      pl_val.push_back(int'(calib_o));
    end
    for (int n = 0; n < LANES; n++)
      if (calib_o[n]) pulse_total[n] <= pulse_total[n] + 1;
    if ((calib_o != '0) && (prev_calib != '0)) bad_calib <= bad_calib + 1;
    else if ($countones(calib_o) > 1) bad_calib <= bad_calib + 1;
    prev_calib <= calib_o;
  end

  int               exp_done;
  logic [LANES-1:0] exp_lock;
  logic [2*LANES-1:0] exp_slips;
  logic             exp_fail;
  int               exp_pc [$];
  int               exp_pv [$];

  // Walks the pass lane by lane; s is the edge at which start_i is accepted.
  task automatic model_pass(input int s);
    int t, c, m, tries, sl;
    bit fin, brk;
    t = s;
    exp_lock = '0; exp_slips = '0; exp_fail = 1'b0;
    exp_pc.delete(); exp_pv.delete();
    for (int n = 0; n < LANES; n++) begin
      tries = 0; sl = 0; fin = 0;
      while (!fin) begin
        c = t + SETTLE; m = 0; brk = 0;
        while (!brk) begin
          if (lane_word(mode[n], off[n], gl_cyc[n], sl, c) == PAT) begin
            m++;
            if (m == MATCHES) begin exp_lock[n] = 1'b1; fin = 1; brk = 1; end
          end else if (tries < 3) begin
            exp_pc.push_back(c + 1); exp_pv.push_back(1 << n);
            sl++; tries++; brk = 1;
          end else begin
            exp_fail = 1'b1; fin = 1; brk = 1;
          end
          if (brk) t = c + 2;
          c++;
        end
      end
      exp_slips[2*n +: 2] = 2'(sl % 4);
    end
    exp_done = t;
  endtask

  task automatic run_pass(input string nm, input bit noise, output int s, output int got_done);
    int pbase, bbase, nobs;
    @(negedge pclk);
    for (int n = 0; n < LANES; n++) begin
      pulse_base[n] = pulse_total[n];
      gl_cyc[n] = (gl_rel[n] < 0) ? -1 : cyc + 1 + gl_rel[n];
    end
    s = cyc + 1;
    pbase = pl_cyc.size();
    bbase = bad_calib;
    model_pass(s);
    start_i = 1'b1;
    @(posedge pclk); #1;
    start_i = 1'b0;
    check({nm, "_start_busy"}, busy_o, 1);
    check({nm, "_start_clr"}, {done_o, fail_o, lock_o, slips_o}, 0);
    got_done = -1;
    for (int i = 0; i < 600; i++) begin
      @(posedge pclk); #1;
      if (done_o) begin got_done = cyc; break; end
      start_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    start_i = 1'b0;
    check({nm, "_done_edge"}, got_done, exp_done);
    check({nm, "_lock"}, lock_o, exp_lock);
    check({nm, "_slips"}, slips_o, exp_slips);
    check({nm, "_fail"}, fail_o, exp_fail);
    @(posedge pclk); #1;
    check({nm, "_idle"}, {busy_o, done_o}, 2'b01);
    nobs = pl_cyc.size() - pbase;
    check({nm, "_npulse"}, nobs, exp_pc.size());
    for (int i = 0; i < nobs && i < exp_pc.size(); i++) begin
      check($sformatf("%s_pulse%0d_cyc", nm, i), pl_cyc[pbase + i], exp_pc[i]);
      check($sformatf("%s_pulse%0d_lane", nm, i), pl_val[pbase + i], exp_pv[i]);
    end
    check({nm, "_calib_shape"}, bad_calib - bbase, 0);
  endtask

  task automatic set_lane(input int n, input int md, input int of, input int gr);
    mode[n] = md; off[n] = of; gl_rel[n] = gr;
  endtask

  initial begin
    int s, d;
    bit found;
    for (int n = 0; n < LANES; n++) begin set_lane(n, 0, 0, -1); gl_cyc[n] = -1; end
    repeat (3) @(posedge pclk);
    #1;
    check("reset_outputs", {calib_o, busy_o, done_o, fail_o, lock_o, slips_o}, 0);
    reset = 1'b0;

    run_pass("aligned", 0, s, d);
    check("aligned_latency", d - s + 1, 27);

    set_lane(0, 0, 0, -1); set_lane(1, 0, 2, -1);
    run_pass("mis2", 0, s, d);

    set_lane(0, 1, 0, -1); set_lane(1, 0, 0, -1);
    run_pass("dead0", 0, s, d);

    set_lane(0, 2, 0, SETTLE + MATCHES - 1); set_lane(1, 0, 0, -1);
    run_pass("glitch", 0, s, d);

    // Reset asserted during the SLIP cycle of lane 1
    set_lane(0, 2, 0, -1); set_lane(1, 0, 2, -1);
    @(negedge pclk);
    start_i = 1'b1;
    @(posedge pclk); #1;
    start_i = 1'b0;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      if (calib_o != '0) begin found = 1; break; end
      @(posedge pclk); #1;
    end
    check("rst_found_slip", found, 1);
    reset = 1'b1;
    @(posedge pclk); #1;
    check("rst_calib", calib_o, 0);
    check("rst_outputs", {busy_o, done_o, fail_o, lock_o, slips_o}, 0);
    reset = 1'b0;
    run_pass("after_rst", 0, s, d);

    set_lane(0, 0, 1, -1); set_lane(1, 0, 3, -1);
    run_pass("noise", 1, s, d);

    for (int r = 0; r < 20; r++) begin
      for (int n = 0; n < LANES; n++)
        set_lane(n, int'($urandom_range(0, 5)) % 3 == 1 ? 1 : int'($urandom_range(0, 1)) * 2,
                 int'($urandom_range(0, 3)),
                 ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 60)) : -1);
      run_pass($sformatf("rnd%0d", r), r[0], s, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
